// File: rtl/arb_qos_pkg.sv
// Shared types and width helpers for the QoS weighted round-robin arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package arb_qos_pkg;

    typedef enum logic {
        ARB_RR  = 1'b0,
        ARB_WRR = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Width of a client index; never below 1 so a port can always be declared.
    function automatic int client_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of a priority class field; a single class still uses 1 bit.
    function automatic int prio_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating-priority picker: first set bit of i_mask strictly after i_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; i_ptr itself is checked last so a lone previous owner can win.
// Ports: i_mask  candidate set
//        i_ptr   last winner
//        o_found any candidate present
//        o_idx   index of chosen candidate
//        o_onehot one-hot of chosen candidate (zero when none)
module arb_rr_pick
    import arb_qos_pkg::*;
#(
    parameter  int NUM_CLIENTS = 4,
    localparam int IDX_W       = client_idx_w(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] i_mask,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic                   o_found,
    output logic [IDX_W-1:0]       o_idx,
    output logic [NUM_CLIENTS-1:0] o_onehot
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_found  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_cand   = '0;
        // Walk ptr+1, ptr+2, ... ptr; the first hit is the closest after the pointer.
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NUM_CLIENTS);
            if (!o_found && i_mask[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
        if (o_found) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arbiter_wrr_qos.sv
// Weighted round-robin arbiter with lock, priority classes and anti-starvation aging.
// Latency: request sampled at edge t is granted at edge t+1 at the earliest; all o_* are flops.
// Backpressure: none; clients hold i_req until granted, tenure ends only on drop/weight/lock release.
// Ports: clk/rst       clock, async active-high reset
//        i_req/i_lock  per-client request and lock (lock honoured for owner only)
//        i_weight      packed per-client weight (W gives W+1 cycles in WRR mode)
//        i_prio        packed per-client class (NUM_PRIO-1 highest)
//        i_mode        0 plain RR, 1 WRR
//        i_age_limit   wait cycles before boost, 0 disables aging
//        o_gnt/o_gnt_id/o_gnt_valid/o_boosted  registered grant
module arbiter_wrr_qos
    import arb_qos_pkg::*;
#(
    parameter  int NUM_CLIENTS  = 4,
    parameter  int WEIGHT_WIDTH = 4,
    parameter  int NUM_PRIO     = 2,
    parameter  int AGE_WIDTH    = 6,
    localparam int IDX_W        = client_idx_w(NUM_CLIENTS),
    localparam int PRIO_W       = prio_w(NUM_PRIO)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            i_req,
    input  logic [NUM_CLIENTS-1:0]            i_lock,
    input  logic [NUM_CLIENTS*WEIGHT_WIDTH-1:0] i_weight,
    input  logic [NUM_CLIENTS*PRIO_W-1:0]     i_prio,
    input  logic                              i_mode,
    input  logic [AGE_WIDTH-1:0]              i_age_limit,
    output logic [NUM_CLIENTS-1:0]            o_gnt,
    output logic [IDX_W-1:0]                  o_gnt_id,
    output logic                              o_gnt_valid,
    output logic                              o_boosted
);

    arb_state_e              r_state;
    logic [IDX_W-1:0]        r_owner;
    logic [IDX_W-1:0]        r_gptr;
    logic [IDX_W-1:0]        r_cptr [NUM_PRIO];
    logic [WEIGHT_WIDTH-1:0] r_cnt;
    logic [AGE_WIDTH-1:0]    r_age  [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0]  r_gnt;
    logic                    r_gnt_vld;
    logic                    r_boosted;

    logic [PRIO_W-1:0]       w_cls [NUM_CLIENTS];
    logic [NUM_PRIO-1:0]     w_cls_any;
    logic [PRIO_W-1:0]       w_top_cls;
    logic [NUM_CLIENTS-1:0]  w_cls_mask;
    logic [NUM_CLIENTS-1:0]  w_boost_mask;
    logic [IDX_W-1:0]        w_cls_ptr;

    logic                    w_bst_found, w_cls_found;
    logic [IDX_W-1:0]        w_bst_idx, w_cls_idx;
    logic [NUM_CLIENTS-1:0]  w_bst_oh, w_cls_oh;

    logic                    w_win_found;
    logic                    w_win_boost;
    logic [IDX_W-1:0]        w_win_idx;
    logic [NUM_CLIENTS-1:0]  w_win_oh;
    logic [WEIGHT_WIDTH-1:0] w_win_weight;
    logic [PRIO_W-1:0]       w_win_cls;

    logic                    w_keep;
    logic                    w_nxt_vld;
    logic [IDX_W-1:0]        w_nxt_idx;

    // Per-client class, clamping out-of-range encodings to the top class.
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_cls[i] = i_prio[i*PRIO_W +: PRIO_W];
            if (int'(w_cls[i]) >= NUM_PRIO) begin
                w_cls[i] = PRIO_W'(NUM_PRIO - 1);
            end
        end
    end

    // Highest requesting class and the requests belonging to it.
    always_comb begin
        w_cls_any = '0;
        w_top_cls = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (i_req[i]) begin
                w_cls_any[w_cls[i]] = 1'b1;
            end
        end
        for (int p = 0; p < NUM_PRIO; p++) begin
            if (w_cls_any[p]) begin
                w_top_cls = PRIO_W'(p);
            end
        end
        w_cls_ptr = r_cptr[w_top_cls];
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_cls_mask[i]   = i_req[i] && (w_cls[i] == w_top_cls);
            w_boost_mask[i] = i_req[i] && (i_age_limit != '0) && (r_age[i] == i_age_limit);
        end
    end

    arb_rr_pick #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick_boost (
        .i_mask   (w_boost_mask),
        .i_ptr    (r_gptr),
        .o_found  (w_bst_found),
        .o_idx    (w_bst_idx),
        .o_onehot (w_bst_oh)
    );

    arb_rr_pick #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick_cls (
        .i_mask   (w_cls_mask),
        .i_ptr    (w_cls_ptr),
        .o_found  (w_cls_found),
        .o_idx    (w_cls_idx),
        .o_onehot (w_cls_oh)
    );

    // Boosted clients override class priority.
    always_comb begin
        w_win_boost  = w_bst_found;
        w_win_found  = w_bst_found || w_cls_found;
        w_win_idx    = w_bst_found ? w_bst_idx : w_cls_idx;
        w_win_oh     = w_bst_found ? w_bst_oh  : w_cls_oh;
        w_win_cls    = w_cls[w_win_idx];
        w_win_weight = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_win_weight = i_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    assign w_keep    = (r_state == ARB_OWNED) && i_req[r_owner] &&
                       (i_lock[r_owner] || (r_cnt != '0));
    assign w_nxt_vld = w_keep || w_win_found;
    assign w_nxt_idx = w_keep ? r_owner : w_win_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_owner   <= '0;
            r_gptr    <= IDX_W'(NUM_CLIENTS - 1);
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_boosted <= 1'b0;
            for (int p = 0; p < NUM_PRIO; p++) begin
                r_cptr[p] <= IDX_W'(NUM_CLIENTS - 1);
            end
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            // Age never exceeds the live limit, which also bounds it below 2^AGE_WIDTH.
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (!i_req[i] || (w_nxt_vld && (w_nxt_idx == IDX_W'(i)))) begin
                    r_age[i] <= '0;
                end else if (r_age[i] >= i_age_limit) begin
                    r_age[i] <= i_age_limit;
                end else begin
                    r_age[i] <= r_age[i] + AGE_WIDTH'(1);
                end
            end

            if (w_keep) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - WEIGHT_WIDTH'(1);
                end
            end else if (w_win_found) begin
                r_state           <= ARB_OWNED;
                r_owner           <= w_win_idx;
                r_gnt             <= w_win_oh;
                r_gnt_vld         <= 1'b1;
                r_boosted         <= w_win_boost;
                r_cnt             <= (arb_mode_e'(i_mode) == ARB_WRR) ? w_win_weight : '0;
                r_gptr            <= w_win_idx;
                r_cptr[w_win_cls] <= w_win_idx;
            end else begin
                // Nobody requesting: release; pointers and last id hold.
                r_state   <= ARB_IDLE;
                r_gnt     <= '0;
                r_gnt_vld <= 1'b0;
                r_boosted <= 1'b0;
                r_cnt     <= '0;
            end
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_id    = r_owner;
    assign o_gnt_valid = r_gnt_vld;
    assign o_boosted   = r_boosted;

endmodule

// File: doc/arbiter_wrr_qos.md
Name: arbiter_wrr_qos

Overview:
Next-generation weighted round-robin arbiter with lock. Adds per-client priority classes, a runtime RR/WRR mode select, and anti-starvation aging that boosts long-waiting clients. It sits in front of a shared resource (bus port, memory channel) and issues a registered one-hot grant plus an encoded grant ID.

Parameters:
NUM_CLIENTS, 4, number of requestors (2..32)
WEIGHT_WIDTH, 4, bits per client weight; weight W grants W+1 cycles
NUM_PRIO, 2, number of priority classes (1..4); class NUM_PRIO-1 is highest
AGE_WIDTH, 6, bits of per-client wait counter and age limit

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
i_req  input  NUM_CLIENTS  request per client
i_lock  input  NUM_CLIENTS  lock per client; only the owner's bit is honoured
i_weight  input  NUM_CLIENTS*WEIGHT_WIDTH  packed weights, client 0 in LSBs
i_prio  input  NUM_CLIENTS*clog2(NUM_PRIO) (min 1)  packed class per client
i_mode  input  1  0 = plain RR (weights treated as 0), 1 = WRR
i_age_limit  input  AGE_WIDTH  wait cycles before boost; 0 disables aging
o_gnt  output  NUM_CLIENTS  one-hot grant, registered
o_gnt_id  output  clog2(NUM_CLIENTS)  index of granted client, valid when o_gnt_valid
o_gnt_valid  output  1  OR of o_gnt
o_boosted  output  1  current grant was won through aging boost

Behaviour:
- Reset (async, while rst=1): o_gnt=0, o_gnt_id=0, o_gnt_valid=0, o_boosted=0, weight counter=0, all age counters=0, global pointer and every class pointer = NUM_CLIENTS-1, so the first search starts at client 0.
- Latency: a request sampled at edge t is granted at the earliest at edge t+1. o_* are flops only.
- States: IDLE (no owner) and OWNED (owner valid). IDLE->OWNED when any request is present. OWNED->OWNED (same owner) on keep. OWNED->OWNED (new owner) on switch with a winner. OWNED->IDLE on switch with no requests.
- Keep rule: i_req[owner] && (i_lock[owner] || cnt>0). On keep, cnt decrements if >0 and otherwise holds at 0. Lock holds indefinitely and ignores weight.
- Switch: the winner is loaded. cnt = i_mode ? weight[winner] : 0. Weight W gives exactly W+1 granted cycles when unlocked and requesting continuously. If the owner drops i_req, the switch happens at the next edge regardless of cnt.
- Winner selection (combinational, used only on switch):
  - Boosted set B = requesting clients with age == i_age_limit (limit != 0). If B is non-empty, pick RR within B from the global pointer, and set o_boosted=1.
  - Otherwise, c = highest class with any request. Pick RR within class c from class pointer c. The candidate closest after the pointer wins.
  - The previous owner is eligible. If it is the sole requestor, it is re-granted with a fresh weight, with no idle cycle.
- Pointers: on every switch-with-winner, global pointer = winner and class pointer[class of winner] = winner. Other class pointers hold. In IDLE, pointers hold.
- Aging, per client each edge:
  - Reset to 0 if not requesting, or if granted at this edge.
  - Otherwise increment, saturating at i_age_limit (and at 2^AGE_WIDTH-1).
  - The current owner's age stays 0.
- No preemption: a higher-class or boosted request waits for the current tenure to end.
- Dynamic inputs: i_weight, i_prio and i_mode changes take effect at the next switch. i_age_limit is compared live.
- Reset mid-tenure: grant drops asynchronously. After release, arbitration restarts from client 0 with ages cleared.

Decomposition:
- Package arb_qos_pkg:
  - CLIENT_IDX_W = clog2(NUM_CLIENTS) and PRIO_W = max(1, clog2(NUM_PRIO)) helper functions.
  - typedef arb_mode_e {ARB_RR=0, ARB_WRR=1}.
  - typedef arb_state_e {ARB_IDLE, ARB_OWNED}.
- Sub-module arb_rr_pick: pure combinational rotating-priority pick (mask, pointer -> found, index, one-hot), parametrised by NUM_CLIENTS.
  - Instantiated once for the boosted set and once for the selected class's masked requests.
  - Final mux chooses between the two.

Test Plan:
- Basic WRR: i_mode=1, weights {0,1,2,3}, all classes 0, all req=1 -> grant cycles client0 x1, client1 x2, client2 x3, client3 x4, repeating.
- RR mode: same setup with i_mode=0 -> each client granted exactly 1 cycle in order 0,1,2,3.
- Lock: client1 owns with weight 0 and i_lock[1]=1 for 10 cycles -> o_gnt=0010 for all 10, switching to client2 one edge after lock drops. An i_lock[3] from a non-owner has no effect.
- Priority: client3 class 1, clients 0-2 class 0, all requesting -> client3 re-granted back to back. Drop req3 -> RR resumes among 0,1,2 from class-0 pointer.
- Aging: client0 class 0, client3 class 1 requesting continuously, weight 0, i_age_limit=4 -> client0 granted with o_boosted=1 after waiting 4 cycles, then client3 again. With i_age_limit=0, client0 never granted.
- Reset/idle: assert rst mid-tenure of client2 -> o_gnt=0 immediately. After release with all req=1 -> first grant is client0 one edge later. No requests -> o_gnt_valid=0 and pointers held.
